load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//   Memory-access controller between the pipeline's MEM stage and data_memory (word-wide, sync read/write at posedge).
//   Accepts byte/half/word loads and stores, aligns and extends load data, and does sub-word stores as read-modify-write.
//   Flags misaligned/out-of-range/illegal-size requests without touching memory. One request in flight at a time.
// PARAMETERS
//   MEM_WORDS  32  number of 32-bit words in data_memory; word index >= MEM_WORDS -> error
// PORTS
//   clock          in   1   system clock, all state updates on posedge
//   reset          in   1   asynchronous, active-high; returns block to IDLE immediately
//   req_valid      in   1   request present
//   req_ready      out  1   block can accept (high only in IDLE, forced 0 while reset high)
//   req_write      in   1   1 = store, 0 = load
//   req_size       in   2   00 byte, 01 half, 10 word, 11 illegal
//   req_signed     in   1   loads only: 1 sign-extend, 0 zero-extend; ignored for word/stores
//   req_address    in   32  byte address
//   req_wdata      in   32  store data, right-justified (byte in [7:0], half in [15:0])
//   resp_valid     out  1   one-cycle completion pulse
//   resp_rdata     out  32  extended load data; 0 for stores and errors; held until next resp
//   resp_error     out  1   valid with resp_valid: misaligned, out-of-range or size 11
//   mem_address    out  32  word-aligned byte address {addr[31:2],2'b00} to data_memory
//   mem_writedata  out  32  full word to data_memory
//   mem_memread    out  1   read strobe, high for exactly one cycle per read
//   mem_memwrite   out  1   write strobe, high for exactly one cycle per write
//   mem_readdata   in   32  data_memory output, valid cycle after the edge that sampled mem_memread
// BEHAVIOUR
//   - States: IDLE, READ, CAPTURE, WRITE, RESP. Accept on posedge with req_valid && req_ready; latch
//     write/size/signed/address/wdata. Inputs ignored outside IDLE.
//   - From IDLE: error -> RESP; load or sub-word store -> READ; word store -> WRITE.
//   - READ: mem_memread=1. -> CAPTURE.
//   - CAPTURE: mem_readdata valid. Load: extract lane, extend, register into resp_rdata -> RESP.
//     Sub-word store: register merged word -> WRITE.
//   - WRITE: mem_memwrite=1, mem_writedata = merged word (or req_wdata for word store). -> RESP.
//   - RESP: resp_valid=1 one cycle -> IDLE. Next request accepted at earliest on the edge after RESP.
//   - Latency, cycles from accept edge to resp_valid cycle inclusive: error 1, word store 2, load 3, sub-word store 4.
//   - Lanes little-endian: byte k = bits[8k+7:8k], k = addr[1:0]; half = bits[16h+15:16h], h = addr[1].
//   - Merge: only the addressed lane replaced by req_wdata[7:0]/[15:0]; other bytes kept from the read word.
//   - Errors: half with addr[0]=1; word with addr[1:0]!=0; size 11; addr[31:2] >= MEM_WORDS.
//     No mem strobe asserted for an errored request.
//   - mem_memread and mem_memwrite never high in the same cycle; both decoded from state, so they drop
//     the moment reset asserts.
//   - Reset: state IDLE, resp_valid=0, resp_error=0, resp_rdata=0, mem_address=0, mem_writedata=0,
//     mem_memread=0, mem_memwrite=0.
//   - Reset mid-operation: request aborted, no resp_valid. Reset in READ/CAPTURE: memory unchanged.
//     Reset asserted before the WRITE-state edge: write suppressed.
// TESTING
//   1. Preload mem[1]=1000: lw addr 4 -> resp_rdata 0x000003E8, resp_valid in 3rd cycle, one memread pulse, no memwrite.
//   2. lb addr 4: signed -> 0xFFFFFFE8; unsigned -> 0x000000E8. lhu addr 6 -> 0x00000000.
//   3. mem[2]=500: sb addr 9 data 0xAB -> read then write 0x0000ABF4, resp at 4th cycle;
//      then lw addr 8 -> 0x0000ABF4.
//   4. sw addr 0 data 0xDEADBEEF -> single memwrite pulse, no memread, resp at 2nd cycle;
//      then lh signed addr 2 -> 0xFFFFDEAD.
//   5. lh addr 1, sw addr 6, size 11, lw addr 128 -> each resp_error=1 and resp_rdata=0 in 1st cycle,
//      no mem strobes, memory unchanged.
//   6. sh addr 2 with reset asserted in CAPTURE -> no memwrite, no resp_valid, req_ready high after
//      reset release, word unchanged.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory-access controller sitting between the MEM stage and a word-wide
//   data_memory with synchronous read and write at posedge. Handles byte,
//   half and word loads/stores, aligns and sign/zero-extends load data, and
//   performs sub-word stores as a read-modify-write of the containing word.
//   Misaligned, out-of-range and illegal-size requests are answered with an
//   error response without any memory strobe. One request in flight at a time.
//
// Ports
//   clock, reset         system clock; asynchronous active-high reset
//   req_valid/req_ready  request handshake (ready only in IDLE, low in reset)
//   req_write            1 = store, 0 = load
//   req_size             00 byte, 01 half, 10 word, 11 illegal
//   req_signed           sign-extend sub-word loads when set
//   req_address          byte address
//   req_wdata            right-justified store data
//   resp_valid           one-cycle completion pulse
//   resp_rdata           extended load data (0 for stores/errors), held
//   resp_error           error flag, meaningful with resp_valid
//   mem_address          word-aligned byte address to data_memory
//   mem_writedata        full word written to data_memory
//   mem_memread          one-cycle read strobe
//   mem_memwrite         one-cycle write strobe
//   mem_readdata         data_memory output, valid in the CAPTURE cycle

module load_store_unit #(
  parameter int MEM_WORDS = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writedata,
  output logic        mem_memread,
  output logic        mem_memwrite,
  input  logic [31:0] mem_readdata
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    WRITE,
    RESP
  } state_t;

  state_t      state;
  logic        lat_write;
  logic        lat_signed;
  logic [1:0]  lat_size;
  logic [1:0]  lat_lane;
  logic [15:0] lat_wdata;

  logic        req_error;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_value;
  logic [31:0] merged_word;

  // The strobes and handshake flags are decoded straight from the state
  // register, so an asynchronous reset drops them in the same instant that
  // the state returns to IDLE. That is what keeps an aborted store from
  // ever reaching memory.
  assign req_ready    = (state == IDLE) && !reset;
  assign resp_valid   = (state == RESP);
  assign mem_memread  = (state == READ);
  assign mem_memwrite = (state == WRITE);

  // Classify the incoming request. An error covers misalignment for the
  // access size, the reserved size code, and any word index beyond the end
  // of data_memory. Erroring requests skip memory entirely.
  always_comb begin
    req_error = 1'b0;
    case (req_size)
      2'b00:   req_error = 1'b0;
      2'b01:   req_error = req_address[0];
      2'b10:   req_error = |req_address[1:0];
      default: req_error = 1'b1;
    endcase
    if (req_address[31:2] >= 30'(MEM_WORDS)) begin
      req_error = 1'b1;
    end
  end

  // Lane handling on the word returned by memory. Lanes are little-endian:
  // byte k lives in bits [8k+7:8k], half h in bits [16h+15:16h]. The load
  // path extracts and extends the addressed lane; the store path rebuilds
  // the word with only the addressed lane replaced by the store data.
  always_comb begin
    byte_sel = mem_readdata[{lat_lane, 3'b000} +: 8];
    half_sel = mem_readdata[{lat_lane[1], 4'b0000} +: 16];
    case (lat_size)
      2'b00:   load_value = {{24{lat_signed & byte_sel[7]}}, byte_sel};
      2'b01:   load_value = {{16{lat_signed & half_sel[15]}}, half_sel};
      default: load_value = mem_readdata;
    endcase
    merged_word = mem_readdata;
    if (lat_size == 2'b00) begin
      merged_word[{lat_lane, 3'b000} +: 8] = lat_wdata[7:0];
    end else begin
      merged_word[{lat_lane[1], 4'b0000} +: 16] = lat_wdata[15:0];
    end
  end

  // Main controller. A request is accepted in IDLE and its fields latched;
  // errors go straight to RESP, word stores go straight to WRITE, and loads
  // and sub-word stores read the word first. The response registers are
  // only written on the transition into RESP so resp_rdata holds its value
  // until the next response.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      lat_write     <= 1'b0;
      lat_signed    <= 1'b0;
      lat_size      <= 2'b00;
      lat_lane      <= 2'b00;
      lat_wdata     <= 16'h0000;
      resp_rdata    <= 32'h0000_0000;
      resp_error    <= 1'b0;
      mem_address   <= 32'h0000_0000;
      mem_writedata <= 32'h0000_0000;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_write  <= req_write;
            lat_signed <= req_signed;
            lat_size   <= req_size;
            lat_lane   <= req_address[1:0];
            lat_wdata  <= req_wdata[15:0];
            if (req_error) begin
              resp_error <= 1'b1;
              resp_rdata <= 32'h0000_0000;
              state      <= RESP;
            end else begin
              mem_address <= {req_address[31:2], 2'b00};
              if (req_write && (req_size == 2'b10)) begin
                mem_writedata <= req_wdata;
                state         <= WRITE;
              end else begin
                state <= READ;
              end
            end
          end
        end
        READ: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          if (lat_write) begin
            mem_writedata <= merged_word;
            state         <= WRITE;
          end else begin
            resp_rdata <= load_value;
            resp_error <= 1'b0;
            state      <= RESP;
          end
        end
        WRITE: begin
          resp_rdata <= 32'h0000_0000;
          resp_error <= 1'b0;
          state      <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Directed bench for load_store_unit with a behavioural word memory.
//   Stimulus pushes the expected response into a queue; an independent
//   monitor pops and compares whenever resp_valid is seen.

module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_address;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_address;
  logic [31:0] mem_writedata;
  logic        mem_memread;
  logic        mem_memwrite;
  logic [31:0] mem_readdata;

  logic [31:0] mem [0:31];
  logic        pl_en;
  logic [4:0]  pl_idx;
  logic [31:0] pl_data;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int accept_cycle = 0;
  int read_count = 0;
  int write_count = 0;

  load_store_unit #(.MEM_WORDS(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_address  (req_address),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_error   (resp_error),
    .mem_address  (mem_address),
    .mem_writedata(mem_writedata),
    .mem_memread  (mem_memread),
    .mem_memwrite (mem_memwrite),
    .mem_readdata (mem_readdata)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // Cycle counter used to measure accept-to-response latency.
  always @(posedge clock) cycle <= cycle + 1;

  // Behavioural data_memory: synchronous write, synchronous read, plus a
  // preload port so the bench can seed words while the DUT is idle.
  always @(posedge clock) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (mem_memwrite) mem[mem_address[6:2]] <= mem_writedata;
    if (mem_memread) mem_readdata <= mem[mem_address[6:2]];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: samples on the falling edge, counts strobes, notes the accept
  // cycle, and compares every response against the head of the scoreboard.
  always @(negedge clock) begin
    exp_t e;
    checkOutput("strobe_overlap", {31'b0, mem_memread & mem_memwrite}, 32'd0);
    if (mem_memread) read_count++;
    if (mem_memwrite) write_count++;
    if (resp_valid) begin
      checkOutput("resp_pending", {31'b0, sb_q.size() > 0}, 32'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checkOutput({e.name, "_rdata"}, resp_rdata, e.rdata);
        checkOutput({e.name, "_error"}, {31'b0, resp_error}, {31'b0, e.err});
        checkOutput({e.name, "_latency"}, 32'(cycle - accept_cycle + 1), 32'(e.lat));
      end
    end
    if (req_valid && req_ready) accept_cycle = cycle + 1;
  end

  task automatic preload(input logic [4:0] idx, input logic [31:0] data);
    pl_idx  = idx;
    pl_data = data;
    pl_en   = 1'b1;
    @(posedge clock); #1;
    pl_en   = 1'b0;
  endtask

  task automatic applyStimulus(input string name, input logic wr, input logic [1:0] size,
                               input logic sgn, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp_rdata,
                               input logic exp_err, input int exp_lat,
                               input int exp_reads, input int exp_writes);
    int r0;
    int w0;
    int n;
    exp_t e;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    checkOutput({name, "_ready"}, {31'b0, req_ready}, 32'd1);
    e.name  = name;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.lat   = exp_lat;
    sb_q.push_back(e);
    r0 = read_count;
    w0 = write_count;
    req_valid   = 1'b1;
    req_write   = wr;
    req_size    = size;
    req_signed  = sgn;
    req_address = addr;
    req_wdata   = wdata;
    @(posedge clock); #1;
    req_valid = 1'b0;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    checkOutput({name, "_done"}, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
    checkOutput({name, "_reads"}, 32'(read_count - r0), 32'(exp_reads));
    checkOutput({name, "_writes"}, 32'(write_count - w0), 32'(exp_writes));
  endtask

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int w0;
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_size    = 2'b00;
    req_signed  = 1'b0;
    req_address = 32'h0;
    req_wdata   = 32'h0;
    pl_en       = 1'b0;
    pl_idx      = 5'd0;
    pl_data     = 32'h0;

    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd0);
    checkOutput("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("rst_resp_error", {31'b0, resp_error}, 32'd0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
    checkOutput("rst_mem_address", mem_address, 32'h0);
    checkOutput("rst_mem_writedata", mem_writedata, 32'h0);
    checkOutput("rst_memread", {31'b0, mem_memread}, 32'd0);
    checkOutput("rst_memwrite", {31'b0, mem_memwrite}, 32'd0);
    reset = 1'b0;

    preload(5'd0, 32'h0000_0000);
    preload(5'd1, 32'd1000);
    preload(5'd2, 32'd500);
    preload(5'd3, 32'h1122_3344);

    $display("[TB] loads from preloaded word");
    applyStimulus("lw_4",   1'b0, 2'b10, 1'b0, 32'd4, 32'h0, 32'h0000_03E8, 1'b0, 3, 1, 0);
    applyStimulus("lb_s_4", 1'b0, 2'b00, 1'b1, 32'd4, 32'h0, 32'hFFFF_FFE8, 1'b0, 3, 1, 0);
    applyStimulus("lbu_4",  1'b0, 2'b00, 1'b0, 32'd4, 32'h0, 32'h0000_00E8, 1'b0, 3, 1, 0);
    applyStimulus("lhu_6",  1'b0, 2'b01, 1'b0, 32'd6, 32'h0, 32'h0000_0000, 1'b0, 3, 1, 0);

    $display("[TB] sub-word store read-modify-write");
    applyStimulus("sb_9",   1'b1, 2'b00, 1'b0, 32'd9, 32'h0000_00AB, 32'h0, 1'b0, 4, 1, 1);
    checkOutput("mem2_after_sb", mem[2], 32'h0000_ABF4);
    applyStimulus("lw_8",   1'b0, 2'b10, 1'b0, 32'd8, 32'h0, 32'h0000_ABF4, 1'b0, 3, 1, 0);

    $display("[TB] word store");
    applyStimulus("sw_0",   1'b1, 2'b10, 1'b0, 32'd0, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 0, 1);
    applyStimulus("lh_s_2", 1'b0, 2'b01, 1'b1, 32'd2, 32'h0, 32'hFFFF_DEAD, 1'b0, 3, 1, 0);
    applyStimulus("lb_s_3", 1'b0, 2'b00, 1'b1, 32'd3, 32'h0, 32'hFFFF_FFDE, 1'b0, 3, 1, 0);

    $display("[TB] upper-lane merges");
    applyStimulus("sh_14",  1'b1, 2'b01, 1'b0, 32'd14, 32'hFFFF_5566, 32'h0, 1'b0, 4, 1, 1);
    checkOutput("mem3_after_sh", mem[3], 32'h5566_3344);
    applyStimulus("sb_15",  1'b1, 2'b00, 1'b0, 32'd15, 32'hFFFF_FF99, 32'h0, 1'b0, 4, 1, 1);
    applyStimulus("lw_12",  1'b0, 2'b10, 1'b0, 32'd12, 32'h0, 32'h9966_3344, 1'b0, 3, 1, 0);

    $display("[TB] error requests");
    applyStimulus("err_lh_1",   1'b0, 2'b01, 1'b1, 32'd1,   32'h0, 32'h0, 1'b1, 1, 0, 0);
    applyStimulus("err_sw_6",   1'b1, 2'b10, 1'b0, 32'd6,   32'h1234_5678, 32'h0, 1'b1, 1, 0, 0);
    applyStimulus("err_size11", 1'b0, 2'b11, 1'b0, 32'd0,   32'h0, 32'h0, 1'b1, 1, 0, 0);
    applyStimulus("err_lw_128", 1'b0, 2'b10, 1'b0, 32'd128, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    checkOutput("mem0_after_err", mem[0], 32'hDEAD_BEEF);
    checkOutput("mem1_after_err", mem[1], 32'd1000);
    checkOutput("mem2_after_err", mem[2], 32'h0000_ABF4);

    $display("[TB] reset during CAPTURE");
    w0 = write_count;
    req_valid   = 1'b1;
    req_write   = 1'b1;
    req_size    = 2'b01;
    req_signed  = 1'b0;
    req_address = 32'd2;
    req_wdata   = 32'h0000_1234;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    checkOutput("abort_memwrite", {31'b0, mem_memwrite}, 32'd0);
    checkOutput("abort_ready_in_reset", {31'b0, req_ready}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    checkOutput("abort_ready_after", {31'b0, req_ready}, 32'd1);
    checkOutput("abort_rdata", resp_rdata, 32'h0);
    repeat (6) @(posedge clock);
    #1;
    checkOutput("abort_writes", 32'(write_count - w0), 32'd0);
    checkOutput("abort_mem0", mem[0], 32'hDEAD_BEEF);
    checkOutput("abort_resp_valid", {31'b0, resp_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
